// File: rtl/alu_seq_pkg.sv
// Shared encodings for the sCPU control sequencer: opcodes, FSM states and instruction fields.
package alu_seq_pkg;

  localparam int unsigned INSTR_W = 8;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned REG_AW  = 2;
  localparam int unsigned IMM_W   = 4;

  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RD_LSB  = 4;
  localparam int unsigned RS_LSB  = 2;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 2'b00,
    OP_LI   = 2'b01,
    OP_BEQ  = 2'b10,
    OP_HALT = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // rb is the ALU B read address: rs for ADD, the rd field for BEQ
  typedef struct packed {
    op_e               op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rb;
    logic [IMM_W-1:0]  imm;
    logic              we;
  } dec_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decode: opcode, register fields, immediate and write intent.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output dec_t               dec_c
);

  op_e op_c;

  assign op_c = op_e'(ir[OP_LSB +: OP_W]);

  always_comb begin
    dec_c     = '0;
    dec_c.op  = op_c;
    dec_c.rd  = ir[RD_LSB +: REG_AW];
    dec_c.rb  = (op_c == OP_BEQ) ? ir[RD_LSB +: REG_AW] : ir[RS_LSB +: REG_AW];
    dec_c.imm = ir[IMM_LSB +: IMM_W];
    dec_c.we  = (op_c == OP_ADD) || (op_c == OP_LI);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the sCPU datapath; owns pc and ir.
// Optional ALU_SEQ_RETIRE_CNT_EN adds a retired-instruction counter output.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [REG_AW-1:0]  rf_raddr_a,
  output logic [REG_AW-1:0]  rf_raddr_b,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_waddr,
  output logic               alu_add,
  output logic [IMM_W-1:0]   alu_imm,
  input  logic               alu_equal,
  output logic               busy,
  output logic               halted
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]        retired_cnt
`endif
);

  state_e             state;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] ir_d_c;
  logic               capture_c;
  logic               start_ok_c;
  dec_t               dec_c;
  logic [PC_W-1:0]    pc_inc_c;
  logic [PC_W-1:0]    pc_br_c;

  // Decode the word ir is about to hold so the read addresses can be registered on the ack edge
  assign capture_c = (state == ST_FETCH) && imem_ack;
  assign ir_d_c    = capture_c ? imem_data : ir;
  assign start_ok_c = start && ((state == ST_IDLE) || (state == ST_HALTED));

  alu_seq_decode u_decode (
    .ir    (ir_d_c),
    .dec_c (dec_c)
  );

  assign pc_inc_c  = pc + PC_W'(1);
  assign pc_br_c   = pc + {{(PC_W-IMM_W){dec_c.imm[IMM_W-1]}}, dec_c.imm};
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      imem_req   <= 1'b0;
      rf_raddr_a <= '0;
      rf_raddr_b <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      alu_add    <= 1'b0;
      alu_imm    <= '0;
      busy       <= 1'b0;
      halted     <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      alu_add <= 1'b0;
      case (state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            pc       <= RESET_PC;
            state    <= ST_FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
            halted   <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            ir         <= imem_data;
            state      <= ST_DECODE;
            imem_req   <= 1'b0;
            rf_raddr_a <= dec_c.rd;
            rf_raddr_b <= dec_c.rb;
            alu_imm    <= dec_c.imm;
          end
        end
        ST_DECODE: begin
          state    <= ST_EXEC;
          rf_we    <= dec_c.we;
          rf_waddr <= dec_c.rd;
          alu_add  <= (dec_c.op == OP_ADD);
        end
        ST_EXEC: begin
          if (dec_c.op == OP_HALT) begin
            state  <= ST_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state    <= ST_FETCH;
            imem_req <= 1'b1;
            pc       <= ((dec_c.op == OP_BEQ) && alu_equal) ? pc_br_c : pc_inc_c;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_RETIRE_CNT_EN
  localparam int unsigned RETIRE_W = 16;

  // Counts completed non-HALT instructions since the last accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (start_ok_c) begin
      retired_cnt <= '0;
    end else if ((state == ST_EXEC) && (dec_c.op != OP_HALT)) begin
      retired_cnt <= retired_cnt + RETIRE_W'(1);
    end
  end
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok_c;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: bench-side register file/ALU/memory plus an ISA-level model.
module tb_alu_sequencer;

  localparam int unsigned      PC_W     = 8;
  localparam logic [PC_W-1:0]  RESET_PC = 8'h00;

  logic            clk = 1'b0;
  logic            rst_n, start, imem_req, imem_ack, rf_we, alu_add, alu_equal, busy, halted;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_data;
  logic [1:0]      rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [3:0]      alu_imm;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [15:0]     retired_cnt;
`endif

  int          nassert = 0;
  int          nfail   = 0;
  logic [7:0]  mem [256];
  logic [7:0]  R   [4];
  logic [7:0]  m_R [4];
  logic [7:0]  m_pc;
  bit          m_halted;
  int          m_retired;
  bit          exp_we, exp_add;
  logic [1:0]  exp_waddr;
  logic [7:0]  exp_wdata;
  int          we_seen, instr_count, wait_left, exp_cycles;
  bit          rand_wait, rand_start, fetch_pending;
  logic [7:0]  flog [$];
  logic [1:0]  wlog_addr [$];
  logic        wlog_add [$];
  logic [7:0]  exp_wrap [6];
  bit          h;

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .rf_raddr_a (rf_raddr_a),
    .rf_raddr_b (rf_raddr_b),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .alu_add    (alu_add),
    .alu_imm    (alu_imm),
    .alu_equal  (alu_equal),
    .busy       (busy),
    .halted     (halted)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Architectural effect of one instruction at m_pc
  task automatic model_exec(input logic [7:0] ins);
    logic [1:0] op, rd, rs;
    logic [3:0] imm;
    logic [7:0] off;
    op  = ins[7:6];
    rd  = ins[5:4];
    rs  = ins[3:2];
    imm = ins[3:0];
    off = {{4{imm[3]}}, imm};
    exp_we  = 1'b0;
    exp_add = 1'b0;
    case (op)
      2'b00: begin exp_we = 1'b1; exp_add = 1'b1; exp_waddr = rd; exp_wdata = m_R[rd] + m_R[rs]; end
      2'b01: begin exp_we = 1'b1; exp_waddr = rd; exp_wdata = {4'h0, imm}; end
      default: ;
    endcase
    if (exp_we) m_R[rd] = exp_wdata;
    if (op == 2'b11) m_halted = 1'b1;
    else begin
      m_retired++;
      if (op == 2'b10 && m_R[rd] == m_R[0]) m_pc = m_pc + off;
      else m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic close_instr();
    if (instr_count > 0) chk("we_count", 32'(we_seen), exp_we ? 32'd1 : 32'd0);
    we_seen = 0;
  endtask

  // One clock of environment: memory responder, register file/ALU, checks; called at negedge
  task automatic step();
    logic [7:0] wv;
    if (fetch_pending) chk("req_held", 32'(imem_req), 32'd1);
    fetch_pending = 1'b0;
    if (imem_req) begin
      chk("fetch_addr", 32'(imem_addr), 32'(m_pc));
      if (wait_left > 0) begin
        imem_ack = 1'b0;
        imem_data = 8'($urandom);
        wait_left--;
        exp_cycles++;
        fetch_pending = 1'b1;
      end else begin
        close_instr();
        instr_count++;
        flog.push_back(imem_addr);
        imem_ack  = 1'b1;
        imem_data = mem[m_pc];
        exp_cycles += 3;
        model_exec(mem[m_pc]);
        wait_left = rand_wait ? int'($urandom_range(0, 3)) : 0;
      end
    end else begin
      imem_ack  = 1'($urandom);
      imem_data = 8'($urandom);
    end
    if (rf_we) begin
      wv = alu_add ? (R[rf_raddr_a] + R[rf_raddr_b]) : {4'h0, alu_imm};
      we_seen++;
      wlog_addr.push_back(rf_waddr);
      wlog_add.push_back(alu_add);
      chk("waddr", 32'(rf_waddr), 32'(exp_waddr));
      chk("alu_add", 32'(alu_add), 32'(exp_add));
      chk("wdata", 32'(wv), 32'(exp_wdata));
      R[rf_waddr] = wv;
    end else begin
      chk("alu_add_no_we", 32'(alu_add), 32'd0);
    end
    chk("busy", 32'(busy), 32'd1);
    alu_equal = (R[rf_raddr_b] == R[0]);
    start = rand_start && ($urandom_range(0, 7) == 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int max_instr, input int first_wait, input bit abort_on_add,
                     output bit did_halt);
    int cycles, budget;
    bit stop;
    flog.delete();
    wlog_addr.delete();
    wlog_add.delete();
    for (int i = 0; i < 4; i++) m_R[i] = R[i];
    m_pc = RESET_PC; m_halted = 1'b0; m_retired = 0;
    we_seen = 0; instr_count = 0; exp_cycles = 0; exp_we = 1'b0;
    fetch_pending = 1'b0; wait_left = first_wait;
    did_halt = 1'b0; stop = 1'b0; cycles = 0; budget = max_instr * 8 + 32;
    start = 1'b1;
    imem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_req", 32'(imem_req), 32'd1);
    chk("start_halted", 32'(halted), 32'd0);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    chk("start_cnt_clear", 32'(retired_cnt), 32'd0);
`endif
    while (!stop && cycles < budget) begin
      if (halted) begin did_halt = 1'b1; stop = 1'b1; end
      else if (abort_on_add && rf_we && alu_add) stop = 1'b1;
      else if (instr_count > max_instr) stop = 1'b1;
      else begin step(); cycles++; end
    end
    start = 1'b0;
    imem_ack = 1'b0;
    chk("run_terminated", 32'(stop), 32'd1);
    if (did_halt) begin
      chk("halt_expected", 32'(m_halted), 32'd1);
      chk("halt_we_count", 32'(we_seen), 32'd0);
      chk("halt_pc", 32'(imem_addr), 32'(m_pc));
      chk("halt_cycles", 32'(cycles), 32'(exp_cycles));
      chk("halt_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) chk("halt_regs", 32'(R[i]), 32'(m_R[i]));
`ifdef ALU_SEQ_RETIRE_CNT_EN
      chk("retired_cnt", 32'(retired_cnt), 32'(m_retired));
`endif
    end
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_add", 32'(alu_add), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_raddr", 32'({rf_raddr_a, rf_raddr_b, rf_waddr}), 32'd0);
    chk("rst_imm", 32'(alu_imm), 32'd0);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
`endif
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("rst_we_hold", 32'(rf_we), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = 8'h00; alu_equal = 1'b0;
    rand_wait = 1'b0; rand_start = 1'b0;
    for (int i = 0; i < 4; i++) R[i] = 8'h00;
    @(negedge clk);
    do_reset(2);

    // Acks with no request must not start anything
    repeat (4) begin
      imem_ack = 1'b1;
      imem_data = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("idle_req", 32'(imem_req), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    imem_ack = 1'b0;

    // LI R1,2 ; LI R2,3 ; ADD R1,R2 ; HALT with zero-wait memory
    fill(8'hC0);
    mem[0] = 8'h52; mem[1] = 8'h63; mem[2] = 8'h18; mem[3] = 8'hC0;
    run(8, 0, 1'b0, h);
    chk("p1_halted", 32'(h), 32'd1);
    chk("p1_pc", 32'(imem_addr), 32'd3);
    chk("p1_nwrites", 32'(wlog_addr.size()), 32'd3);
    chk("p1_waddr0", 32'(wlog_addr[0]), 32'd1);
    chk("p1_waddr1", 32'(wlog_addr[1]), 32'd2);
    chk("p1_waddr2", 32'(wlog_addr[2]), 32'd1);
    chk("p1_add0", 32'(wlog_add[0]), 32'd0);
    chk("p1_add1", 32'(wlog_add[1]), 32'd0);
    chk("p1_add2", 32'(wlog_add[2]), 32'd1);
    chk("p1_r1", 32'(R[1]), 32'd5);

    // Same program restarted from HALTED with a 4-cycle ack delay on the first fetch
    run(8, 4, 1'b0, h);
    chk("p2_halted", 32'(h), 32'd1);
    chk("p2_first_fetch", 32'(flog[0]), 32'd0);

    // BEQ 0x9E at 0x10 with R1 == R0: taken to 0x0E
    fill(8'hC0);
    mem[0] = 8'h40; mem[1] = 8'h50; mem[2] = 8'h87; mem[9] = 8'h87; mem[16] = 8'h9E;
    run(16, 0, 1'b0, h);
    chk("beq_t_halted", 32'(h), 32'd1);
    chk("beq_t_at10", 32'(flog[4]), 32'h10);
    chk("beq_t_pc", 32'(imem_addr), 32'h0E);

    // PC wrap: BEQ at 0x01 (imm -2, taken) to 0xFF, LI at 0xFF wraps to 0x00
    fill(8'hC0);
    mem[0] = 8'h40; mem[1] = 8'h9E; mem[255] = 8'h51;
    exp_wrap = '{8'h00, 8'h01, 8'hFF, 8'h00, 8'h01, 8'h02};
    run(16, 0, 1'b0, h);
    chk("wrap_halted", 32'(h), 32'd1);
    chk("wrap_nfetch", 32'(flog.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("wrap_fetch", 32'(flog[i]), 32'(exp_wrap[i]));

    // BEQ 0x9E at 0x10 with R1 != R0: falls through to 0x11
    fill(8'hC0);
    mem[0] = 8'h40; mem[1] = 8'h51; mem[2] = 8'h87; mem[9] = 8'h87; mem[16] = 8'h9E;
    run(16, 0, 1'b0, h);
    chk("beq_n_halted", 32'(h), 32'd1);
    chk("beq_n_pc", 32'(imem_addr), 32'h11);

    // Reset during the EXEC cycle of an ADD, then restart
    fill(8'hC0);
    mem[0] = 8'h52; mem[1] = 8'h18; mem[2] = 8'hC0;
    run(8, 0, 1'b1, h);
    chk("abort_at_add", 32'(rf_we & alu_add), 32'd1);
    chk("abort_pc", 32'(imem_addr), 32'd1);
    do_reset(2);
    run(8, 0, 1'b0, h);
    chk("restart_halted", 32'(h), 32'd1);
    chk("restart_fetch", 32'(flog[0]), 32'(RESET_PC));
    chk("restart_pc", 32'(imem_addr), 32'd2);

    // Random programs, random ack latency, stray start pulses; resets cut off long runs
    rand_wait = 1'b1;
    rand_start = 1'b1;
    repeat (8) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run(30, int'($urandom_range(0, 3)), 1'b0, h);
      if (!h) do_reset(1 + int'($urandom_range(0, 2)));
    end
    rand_wait = 1'b0;
    rand_start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
